vram_arbiter: RTL and testbench

- Shares one synchronous single-port video RAM between two requesters: the raster scanout fetch (video) and the host/CPU port.
- Sits between the VGA timing/pixel pipeline and the VRAM macro.
- Video gets strict priority while the raster is inside the fetch window; elsewhere the two requesters alternate round-robin.
- Read data is returned with a fixed 1-cycle latency, tagged to the requester that issued the read.

---
 rtl/video_pkg.sv | 22 ++
 rtl/vram_arb_rr.sv | 37 +++
 rtl/vram_arbiter.sv | 108 ++++++++++
 tb/tb_vram_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video-side types: grant/read-tag encoding and VGA 640x480 timing constants.
package video_pkg;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_VID  = 2'd1,
    G_CPU  = 2'd2
  } grant_t;

  // 640x480 @ 60 Hz, 25 MHz pixel clock; the timing generator derives vid_window from these.
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/vram_arb_rr.sv
// Two-way VRAM grant: video wins inside the fetch window, otherwise round-robin on last grant.
module vram_arb_rr
  import video_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic vid_window,
  input  logic vid_req,
  input  logic cpu_req,
  output logic vid_gnt,
  output logic cpu_gnt
);

  grant_t last_q;

  // Grants are suppressed while reset is asserted so nothing is acked during reset.
  always_comb begin
    vid_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (reset_n) begin
      if (vid_req && (vid_window || !cpu_req || last_q == G_CPU))
        vid_gnt = 1'b1;
      else if (cpu_req)
        cpu_gnt = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      last_q <= G_CPU;
    else if (vid_gnt)
      last_q <= G_VID;
    else if (cpu_gnt)
      last_q <= G_CPU;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM sharing between raster fetch and host port; 1-cycle tagged read return.
module vram_arbiter
  import video_pkg::*;
#(
  parameter int AW      = 17,
  parameter int DW      = 8,
  parameter int MAXWAIT = 63
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          vid_window,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic          vid_valid,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_valid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_starved,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAXWAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXWAIT);

  logic          vid_gnt, cpu_gnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] vid_rdata_q, cpu_rdata_q;
  grant_t        tag_q;
  logic [CW-1:0] wait_q, wait_next;

  vram_arb_rr u_rr (
    .clock      (clock),
    .reset_n    (reset_n),
    .vid_window (vid_window),
    .vid_req    (vid_req),
    .cpu_req    (cpu_req),
    .vid_gnt    (vid_gnt),
    .cpu_gnt    (cpu_gnt)
  );

  assign vid_ack = vid_gnt;
  assign cpu_ack = cpu_gnt;
  assign mem_we  = cpu_gnt & cpu_we;

  // Address and write data hold their last issued value on idle cycles.
  always_comb begin
    mem_addr = addr_q;
    if (vid_gnt)
      mem_addr = vid_addr;
    else if (cpu_gnt)
      mem_addr = cpu_addr;
  end

  assign mem_wdata = cpu_gnt ? cpu_wdata : wdata_q;

  // In the return cycle the RAM output is passed straight through, then held.
  assign vid_valid = (tag_q == G_VID);
  assign cpu_valid = (tag_q == G_CPU);
  assign vid_rdata = vid_valid ? mem_rdata : vid_rdata_q;
  assign cpu_rdata = cpu_valid ? mem_rdata : cpu_rdata_q;

  always_comb begin
    wait_next = wait_q;
    if (cpu_gnt)
      wait_next = '0;
    else if (cpu_req && wait_q != CNT_MAX)
      wait_next = wait_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      tag_q       <= G_NONE;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
      wait_q      <= '0;
      cpu_starved <= 1'b0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      if (vid_gnt)
        tag_q <= G_VID;
      else if (cpu_gnt && !cpu_we)
        tag_q <= G_CPU;
      else
        tag_q <= G_NONE;
      if (vid_valid)
        vid_rdata_q <= mem_rdata;
      if (cpu_valid)
        cpu_rdata_q <= mem_rdata;
      wait_q <= wait_next;
      if (wait_next == CNT_MAX)
        cpu_starved <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: vector table, reference scoreboard, corner sequences.
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        vid_window, vid_req, cpu_req, cpu_we;
  logic [16:0] vid_addr, cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        vid_ack, vid_valid, cpu_ack, cpu_valid, cpu_starved, mem_we;
  logic [7:0]  vid_rdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [16:0] mem_addr;

  always #5 clock = ~clock;

  vram_arbiter #(.AW(17), .DW(8), .MAXWAIT(63)) dut (
    .clock(clock), .reset_n(reset_n),
    .vid_window(vid_window), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_ack(vid_ack), .vid_valid(vid_valid), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
    .cpu_starved(cpu_starved),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      passed++;
  endtask

  function automatic logic [7:0] init_val(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'b0, a[16]};
  endfunction

  // RAM model driven purely by the DUT's memory port.
  logic [7:0] ram [logic [16:0]];
  always @(posedge clock) begin
    mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : init_val(mem_addr);
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  // Reference model state (built from stimulus only).
  typedef struct { int who; logic [7:0] data; } exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [7:0]  shadow [logic [16:0]];
  int          g;
  int          ref_last, ref_cnt;
  logic        ref_starved;
  logic [7:0]  ref_vrd, ref_crd;
  logic [16:0] ref_addr;
  logic        check_en = 1'b0;

  function automatic logic [7:0] model_rd(input logic [16:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic clear_ref();
    q.delete();
    ref_last = 2; ref_cnt = 0; ref_starved = 1'b0;
    ref_vrd = 8'h0; ref_crd = 8'h0; ref_addr = 17'h0;
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      case ({vid_req, cpu_req})
        2'b11:   g = vid_window ? 1 : (ref_last == 1 ? 2 : 1);
        2'b10:   g = 1;
        2'b01:   g = 2;
        default: g = 0;
      endcase
      chk("vid_ack", 32'(vid_ack), 32'(g == 1));
      chk("cpu_ack", 32'(cpu_ack), 32'(g == 2));
      if (g == 1) ref_addr = vid_addr;
      if (g == 2) ref_addr = cpu_addr;
      chk("mem_addr", 32'(mem_addr), 32'(ref_addr));
      chk("mem_we", 32'(mem_we), 32'(g == 2 && cpu_we));
      if (g == 2 && cpu_we) chk("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
      if (q.size() > 0) e = q.pop_front();
      else begin e.who = 0; e.data = 8'h0; end
      chk("vid_valid", 32'(vid_valid), 32'(e.who == 1));
      chk("cpu_valid", 32'(cpu_valid), 32'(e.who == 2));
      if (e.who == 1) ref_vrd = e.data;
      if (e.who == 2) ref_crd = e.data;
      chk("vid_rdata", 32'(vid_rdata), 32'(ref_vrd));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(ref_crd));
      chk("cpu_starved", 32'(cpu_starved), 32'(ref_starved));
      if (g == 2) ref_cnt = 0;
      else if (cpu_req && ref_cnt < 63) ref_cnt++;
      if (ref_cnt >= 63) ref_starved = 1'b1;
      if (g == 1) q.push_back('{1, model_rd(vid_addr)});
      else if (g == 2 && !cpu_we) q.push_back('{2, model_rd(cpu_addr)});
      else q.push_back('{0, 8'h0});
      if (g == 2 && cpu_we) shadow[cpu_addr] = cpu_wdata;
      if (g != 0) ref_last = g;
    end
  end

  typedef struct {
    logic win, vr, cr, we;
    logic [16:0] va, ca;
    logic [7:0] wd;
    logic ev, ec;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic win, logic vr, logic cr, logic we,
                              logic [16:0] va, logic [16:0] ca, logic [7:0] wd,
                              logic ev, logic ec);
    vec_t v;
    v.win = win; v.vr = vr; v.cr = cr; v.we = we;
    v.va = va; v.ca = ca; v.wd = wd; v.ev = ev; v.ec = ec;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    vid_window = v.win; vid_req = v.vr; cpu_req = v.cr; cpu_we = v.we;
    vid_addr = v.va; cpu_addr = v.ca; cpu_wdata = v.wd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // After the first tie (VID), continuous contention alternates C,V,C.
    vecs.push_back(mk(0,1,1,0,17'h100,17'h200,8'h00,0,1));
    vecs.push_back(mk(0,1,1,0,17'h100,17'h200,8'h00,1,0));
    vecs.push_back(mk(0,1,1,0,17'h100,17'h200,8'h00,0,1));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1,1,1,0,17'h100,17'h200,8'h00,1,0));
    vecs.push_back(mk(0,1,1,0,17'h100,17'h200,8'h00,0,1));
    vecs.push_back(mk(0,1,0,0,17'h101,17'h200,8'h00,1,0));
    vecs.push_back(mk(0,0,1,0,17'h100,17'h202,8'h00,0,1));
    vecs.push_back(mk(0,0,0,0,17'h100,17'h200,8'h00,0,0));
    vecs.push_back(mk(1,0,1,0,17'h100,17'h203,8'h00,0,1));
    vecs.push_back(mk(0,1,1,0,17'h104,17'h200,8'h00,1,0));
    vecs.push_back(mk(0,0,1,1,17'h100,17'h01234,8'h5A,0,1));
    vecs.push_back(mk(0,0,1,0,17'h100,17'h01234,8'h00,0,1));
    vecs.push_back(mk(0,0,1,1,17'h100,17'h00777,8'hC3,0,1));
    vecs.push_back(mk(0,1,0,0,17'h00777,17'h200,8'h00,1,0));
    vecs.push_back(mk(0,0,0,0,17'h100,17'h200,8'h00,0,0));

    // Reset held with both requesters active.
    reset_n = 1'b0;
    drive(mk(0,1,1,0,17'h100,17'h200,8'h00,0,0));
    clear_ref();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_acks", 32'({vid_ack, cpu_ack}), 32'(0));
      chk("rst_mem_we", 32'(mem_we), 32'(0));
      chk("rst_valids", 32'({vid_valid, cpu_valid}), 32'(0));
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    check_en = 1'b1;
    @(negedge clock);
    chk("first_tie_vid", 32'({vid_ack, cpu_ack}), 32'(2));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock); #1;
      drive(vecs[i]);
      @(negedge clock);
      chk($sformatf("vec%0d_acks", i), 32'({vid_ack, cpu_ack}), 32'({vecs[i].ev, vecs[i].ec}));
      if (i == 12) chk("no_starve_after_window", 32'(cpu_starved), 32'(0));
    end
    @(negedge clock);

    // Starvation: window held with both requesting for 64 cycles.
    @(posedge clock); #1;
    drive(mk(1,1,1,0,17'h300,17'h301,8'h00,0,0));
    for (int j = 1; j <= 64; j++) begin
      @(negedge clock);
      if (j == 63) chk("starved_before_63", 32'(cpu_starved), 32'(0));
      if (j == 64) chk("starved_at_63", 32'(cpu_starved), 32'(1));
      if (j < 64) begin @(posedge clock); #1; end
    end
    @(posedge clock); #1;
    drive(mk(0,0,1,0,17'h300,17'h301,8'h00,0,0));
    @(negedge clock);
    chk("starved_cpu_served", 32'(cpu_ack), 32'(1));
    @(posedge clock); #1;
    drive(mk(0,0,0,0,17'h300,17'h301,8'h00,0,0));
    @(negedge clock);
    chk("starved_sticky", 32'(cpu_starved), 32'(1));

    // Reset asserted in the cycle after a video read ack.
    @(posedge clock); #1;
    drive(mk(0,1,0,0,17'h155,17'h301,8'h00,0,0));
    @(negedge clock);
    chk("midrst_ack", 32'(vid_ack), 32'(1));
    @(posedge clock); #1;
    check_en = 1'b0;
    reset_n = 1'b0;
    drive(mk(0,0,0,0,17'h155,17'h301,8'h00,0,0));
    @(negedge clock);
    chk("midrst_valid_in_reset", 32'(vid_valid), 32'(0));
    @(posedge clock); #1;
    reset_n = 1'b1;
    clear_ref();
    check_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("midrst_no_valid", 32'(vid_valid), 32'(0));
      chk("midrst_starved_clear", 32'(cpu_starved), 32'(0));
    end
    check_en = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
